// File: rtl/cut_driver.sv
// rtl/cut_driver.sv - half-step blade stepper sequencer; optional macro CUT_DRIVER_HOLD_TORQUE_EN keeps coils energised in IDLE
module cut_driver #(
  parameter int STEP_CYCLES = 250000,
  parameter int DIR_SETTLE  = 25000,
  parameter int POS_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             direction_i,
  input  logic             pos_clr_i,
  output logic [3:0]       coil_o,
  output logic             step_o,
  output logic             busy_o,
  output logic [POS_W-1:0] position_o
);

  // One counter serves both the step interval and the reversal settle time.
  localparam int CNT_MAX = (STEP_CYCLES > DIR_SETTLE) ? STEP_CYCLES : DIR_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DIR_SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REV_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             en_q, dir_q;
  logic             snap_q, snap_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_d;
  logic [POS_W-1:0] pos_d;

  // Half-step pattern {A, B, A', B'} for each phase index.
  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Register the controller inputs once; every decision uses these copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      en_q  <= en_i;
      dir_q <= direction_i;
    end
  end

  // Sequencer next-state: enable loss wins, then reversal, then step terminal count.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_q) begin
          state_d = RUN;
          snap_d  = dir_q;
        end
      end
      RUN: begin
        if (!en_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dir_q != snap_q) begin
          state_d = REV_WAIT;
          cnt_d   = '0;
          snap_d  = dir_q;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          step_d  = 1'b1;
          phase_d = snap_q ? (phase_q - 3'd1) : (phase_q + 3'd1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REV_WAIT: begin
        if (!en_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dir_q != snap_q) begin
          cnt_d  = '0;
          snap_d = dir_q;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Position next value: a clear overrides a coincident step.
  always_comb begin
    pos_d = position_o;
    if (pos_clr_i) begin
      pos_d = '0;
    end else if (step_d) begin
      pos_d = snap_q ? (position_o - POS_W'(1)) : (position_o + POS_W'(1));
    end
  end

  // Sequencer state, step pulse, busy flag and position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= 1'b0;
      phase_q    <= 3'd0;
      cnt_q      <= '0;
      step_o     <= 1'b0;
      busy_o     <= 1'b0;
      position_o <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      step_o     <= step_d;
      busy_o     <= (state_d != IDLE);
      position_o <= pos_d;
    end
  end

`ifdef CUT_DRIVER_HOLD_TORQUE_EN
  logic hold_q;

  // Remember that the motor has been driven once so IDLE keeps holding torque.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
    end else if (state_q != IDLE) begin
      hold_q <= 1'b1;
    end
  end

  assign coil_o = ((state_q != IDLE) || hold_q) ? phase_pattern(phase_q) : 4'b0000;
`else
  assign coil_o = (state_q != IDLE) ? phase_pattern(phase_q) : 4'b0000;
`endif

endmodule

// File: doc/cut_driver.md
Name: cut_driver

Overview:
- Stepper phase sequencer that sits between the cutter controller and the blade motor's H-bridge.
- Consumes the controller's enable and direction outputs.
- Produces half-step coil patterns: 0.9 deg per step on a 1.8 deg motor, one step per STEP_CYCLES clocks.
- Tracks signed blade position and reports busy and step events back to the controller.

Parameters:
- STEP_CYCLES, 250000, clocks per half-step (10 ms at 25 MHz); legal range >= 2.
- DIR_SETTLE, 25000, clocks with no stepping after a direction reversal; legal range >= 1.
- POS_W, 16, width of the signed position counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en_i  input  1  drive enable from the controller.
- direction_i  input  1  0 = clockwise, 1 = counterclockwise.
- pos_clr_i  input  1  synchronous clear of position_o.
- coil_o  output  4  coil drive pattern {A, B, A', B'}.
- step_o  output  1  one-cycle pulse on each phase advance.
- busy_o  output  1  high in RUN or REV_WAIT.
- position_o  output  POS_W  signed step count, clockwise positive.

Behaviour:
- Reset values (rst high, async): state IDLE, phase index 0, clock counter 0, coil_o 4'b0000, step_o 0, busy_o 0, position_o 0, registered inputs 0.
- Input registering: en_i and direction_i are registered once. All decisions use the registered copies, so input-to-effect latency is 1 cycle.
- Phase table (index -> coil_o): 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
  - Clockwise: index +1 mod 8 (7 -> 0).
  - Counterclockwise: index -1 mod 8 (0 -> 7).
- IDLE:
  - coil_o = 0000; clock counter held at 0.
  - Registered en = 1 -> RUN. The direction snapshot is latched on entry.
  - coil_o shows the current phase from the first RUN cycle; no step on entry.
- RUN:
  - Clock counter increments each cycle.
  - At STEP_CYCLES-1: counter returns to 0, phase advances per the snapshot, step_o pulses for 1 cycle, position_o changes by +1 (cw) or -1 (ccw).
  - First step therefore occurs STEP_CYCLES cycles after entry.
- Direction change in RUN (registered direction differs from snapshot): go to REV_WAIT, clear counter, no step that cycle, update snapshot.
- REV_WAIT:
  - coil_o holds the current phase; counter counts to DIR_SETTLE-1.
  - Then RUN with counter 0.
  - A further direction toggle during REV_WAIT restarts the settle count.
- en low: in RUN or REV_WAIT, registered en = 0 -> IDLE next cycle and counter cleared. en low beats a coincident step terminal count: no step, position unchanged.
- Phase retention: phase index is retained across IDLE. Re-enable resumes from the retained phase and never jumps.
- position_o:
  - Two's-complement, wraps silently (max + 1 -> min).
  - pos_clr_i beats a coincident step: position_o = 0 next cycle; phase is unaffected.
- busy_o is a registered decode of state (RUN or REV_WAIT).
- Reset mid-step: all state returns to reset values immediately; coils de-energize asynchronously.

Optional Feature:
- Macro: CUT_DRIVER_HOLD_TORQUE_EN.
- Defined: in IDLE, coil_o keeps the last phase pattern (holding torque keeps the blade parked). Coils are 0000 only after reset, until the first RUN entry.
- Undefined: coil_o = 0000 whenever state is IDLE (default, lower power).
- All other behaviour is identical in both builds.

Test Plan (STEP_CYCLES=4, DIR_SETTLE=3, POS_W=8):
1. Reset, then en_i=1, direction_i=0 for 20 cycles -> coil_o=1000 from cycle 2; step_o pulses every 4 cycles; coil sequence 1100, 0100, 0110, 0010; position_o=4 after 4 pulses; busy_o=1.
2. Run cw to phase 2, then set direction_i=1 -> no step for 3 cycles (REV_WAIT); next step pulse gives coil_o=1100; position_o decrements by 1.
3. Drop en_i on the same cycle the counter would reach 3 -> no step_o, position unchanged, busy_o=0 after 2 cycles. Re-enable -> same phase pattern resumes.
4. Run ccw from index 0 -> index 7 (1001); position 0 -> -1 (8'hFF). Run cw from position 127 -> wraps to -128.
5. Assert pos_clr_i on a step cycle -> position_o=0, coil phase still advances.
6. Assert rst mid-RUN -> coil_o=0000, position_o=0, busy_o=0 asynchronously. With CUT_DRIVER_HOLD_TORQUE_EN defined, en low after stepping leaves coil_o at the last pattern.
